mesh_pipe_array_valid: RTL and testbench
========================================

// Module: mesh_pipe_array_valid
// PURPOSE
//  Linear array of PIPE_ARRAY_SIZE independent pipeline lanes for mesh links: LSB lane, MSB lane and SIZE-2 MID lanes.
//  Each lane carries data plus a valid bit, with per-lane depth set by position.
//  Adds global stall, flush, async reset and per-lane occupancy tracking.
//  Control logic uses lane_busy and drained to know when in-flight mesh traffic has drained.
// PARAMETERS
//  LSB_PIPE_DEPTH   1   stages in lane 0 (bits [WIDTH-1:0])
//  MID_PIPE_DEPTH   2   stages in each lane 1..SIZE-2
//  MSB_PIPE_DEPTH   1   stages in lane SIZE-1
//  WIDTH            36  data bits per lane
//  PIPE_ARRAY_SIZE  4   lane count, >=2 (SIZE=2 means no MID lanes)
//  COUNT_WIDTH is a localparam: clog2(max depth + 1), minimum 1.
// PORTS
//  clock       in   1                 rising-edge clock
//  reset       in   1                 asynchronous, active-high
//  enable      in   1                 1 = all lanes advance one stage this cycle; 0 = hold
//  flush       in   1                 1 = discard all in-flight valid data
//  in          in   WIDTH*SIZE        lane i data at [i*WIDTH +: WIDTH]
//  in_valid    in   SIZE              lane i input valid
//  out         out  WIDTH*SIZE        lane i delayed data
//  out_valid   out  SIZE              lane i delayed valid
//  lane_busy   out  SIZE              lane i holds >=1 valid entry
//  drained     out  1                 no lane holds any valid entry (~|lane_busy)
// BEHAVIOUR
//  Reset: async assert clears immediately, without a clock edge.
//   - Cleared: every stage data reg, every valid bit, every occupancy counter.
//   - Outputs: out=0, out_valid=0, lane_busy=0, drained=1.
//   - Reset mid-operation drops all in-flight data; there is no partial retention.
//  Lane of depth D>0: registers s[0..D-1] with valid v[0..D-1]; out=s[D-1], out_valid=v[D-1].
//  Edge, priority high->low:
//   1) flush=1: all v<=0 and all counts<=0. Data regs keep their values.
//      in/in_valid sampled this edge are discarded, even when enable=1.
//   2) enable=1: s[0]<=in, v[0]<=in_valid, s[k]<=s[k-1], v[k]<=v[k-1].
//      Data shifts even when valid=0.
//   3) enable=0: everything holds. out/out_valid are stable; input is ignored.
//  Latency: exactly D enabled edges. Bubbles (enable=0) stretch it in wall-clock time only.
//  Occupancy per lane: count' = count + (enable&in_valid) - (enable&v[D-1]).
//   - Range is 0..D by construction; no overflow or underflow.
//   - Simultaneous enter+exit leaves count unchanged.
//   - lane_busy[i] = (count_i != 0), registered-derived.
//   - count_i always equals popcount(v) of the lane; this is a checked invariant.
//  Depth 0 lane: combinational wire, out=in and out_valid=in_valid.
//   - That lane's lane_busy is forced to 0; enable, flush and reset have no effect on it.
//   - drained ignores depth-0 lanes.
//  Lanes never interact. Only enable, flush and reset are shared.
//  No backpressure toward the source: the upstream agent must honour enable=0, or its data is lost.
// TESTING
//  1 Reset: assert reset mid-stream with 3 valid words in flight -> same-cycle out_valid=0, lane_busy=0, drained=1, out=0.
//  2 Latency, MID=2, enable=1: lane1 in=0xABC, valid=1 at edge n -> out=0xABC, out_valid=1 after edge n+2; lane_busy=1 on edges n+1..n+2, 0 after n+3 with no new input.
//  3 Stall: enable=0 for 5 cycles between entry and exit -> word appears after 2 enabled edges; out held constant throughout the stall.
//  4 Flush with enable=1 and in_valid=all-ones -> next cycle all out_valid=0, counts=0, drained=1; the input word never appears.
//  5 Streaming SIZE=4, valid pattern 1,0,1,1 per lane -> identical pattern at output after each lane depth; count never exceeds D; invariant count==popcount(v) holds every cycle.
//  6 Edge configs: SIZE=2 (no MID), and LSB_PIPE_DEPTH=0 -> lane0 out==in same cycle; drained unaffected by lane0 traffic.

Source files
------------

// File: rtl/mesh_pipe_array_valid.sv
// mesh_pipe_array_valid
//   A row of independent data+valid delay lanes for mesh links. Lane 0 uses
//   LSB_PIPE_DEPTH stages, the last lane uses MSB_PIPE_DEPTH stages, and every
//   lane in between uses MID_PIPE_DEPTH stages. The lanes share a stall
//   (enable), a flush and an async reset. Each lane keeps an occupancy count,
//   which lets control logic tell when in-flight traffic has drained.
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high
//   enable     1 = every lane advances one stage; 0 = every lane holds
//   flush      drops all valid bits and counts; data registers keep their values
//   in         lane i data at [i*WIDTH +: WIDTH]
//   in_valid   lane i input valid
//   out        lane i delayed data
//   out_valid  lane i delayed valid
//   lane_busy  lane i holds at least one valid entry
//   drained    no lane holds a valid entry
module mesh_pipe_array_valid #(
  parameter int LSB_PIPE_DEPTH  = 1,
  parameter int MID_PIPE_DEPTH  = 2,
  parameter int MSB_PIPE_DEPTH  = 1,
  parameter int WIDTH           = 36,
  parameter int PIPE_ARRAY_SIZE = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             flush,
  input  logic [WIDTH*PIPE_ARRAY_SIZE-1:0] in,
  input  logic [PIPE_ARRAY_SIZE-1:0]       in_valid,
  output logic [WIDTH*PIPE_ARRAY_SIZE-1:0] out,
  output logic [PIPE_ARRAY_SIZE-1:0]       out_valid,
  output logic [PIPE_ARRAY_SIZE-1:0]       lane_busy,
  output logic                             drained
);

  localparam int MAX_DEPTH_LM = (LSB_PIPE_DEPTH > MID_PIPE_DEPTH) ? LSB_PIPE_DEPTH : MID_PIPE_DEPTH;
  localparam int MAX_DEPTH    = (MAX_DEPTH_LM > MSB_PIPE_DEPTH) ? MAX_DEPTH_LM : MSB_PIPE_DEPTH;
  localparam int COUNT_WIDTH  = (MAX_DEPTH < 1) ? 1 : $clog2(MAX_DEPTH + 1);

  function automatic int lane_depth(input int idx);
    if (idx == 0)                        return LSB_PIPE_DEPTH;
    else if (idx == PIPE_ARRAY_SIZE - 1) return MSB_PIPE_DEPTH;
    else                                 return MID_PIPE_DEPTH;
  endfunction

  for (genvar i = 0; i < PIPE_ARRAY_SIZE; i++) begin : g_lane
    localparam int D = lane_depth(i);

    if (D == 0) begin : g_wire
      // A zero-depth lane is a plain wire and never counts as occupied.
      assign out[i*WIDTH +: WIDTH] = in[i*WIDTH +: WIDTH];
      assign out_valid[i]          = in_valid[i];
      assign lane_busy[i]          = 1'b0;
    end else begin : g_pipe
      logic [WIDTH-1:0]       s_q [D];
      logic [WIDTH-1:0]       s_d [D];
      logic [D-1:0]           v_q;
      logic [D-1:0]           v_d;
      logic [COUNT_WIDTH-1:0] cnt_q;
      logic [COUNT_WIDTH-1:0] cnt_d;

      always_comb begin
        s_d   = s_q;
        v_d   = v_q;
        cnt_d = cnt_q;
        if (flush) begin
          // Flush wins over enable; the word presented this edge is dropped too.
          v_d   = '0;
          cnt_d = '0;
        end else if (enable) begin
          s_d[0] = in[i*WIDTH +: WIDTH];
          v_d[0] = in_valid[i];
          for (int k = 1; k < D; k++) begin
            s_d[k] = s_q[k-1];
            v_d[k] = v_q[k-1];
          end
          // Enter and exit in the same cycle cancel out; the count stays in 0..D.
          cnt_d = cnt_q + COUNT_WIDTH'(in_valid[i]) - COUNT_WIDTH'(v_q[D-1]);
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) s_q[k] <= '0;
          v_q   <= '0;
          cnt_q <= '0;
        end else begin
          s_q   <= s_d;
          v_q   <= v_d;
          cnt_q <= cnt_d;
        end
      end

      assign out[i*WIDTH +: WIDTH] = s_q[D-1];
      assign out_valid[i]          = v_q[D-1];
      assign lane_busy[i]          = (cnt_q != '0);
    end
  end

  // Zero-depth lanes always report lane_busy=0, so they never affect drained.
  assign drained = ~|lane_busy;

endmodule

// File: tb/tb_mesh_pipe_array_valid.sv
module tb_mesh_pipe_array_valid;
  localparam int W  = 36;
  localparam int N  = 4;
  localparam int W2 = 8;
  localparam int DEP [N] = '{1, 2, 2, 1};

  logic           clock = 1'b0;
  logic           reset;
  logic           enable;
  logic           flush;
  logic [W*N-1:0] din;
  logic [N-1:0]   vin;
  logic [W*N-1:0] out;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   lane_busy;
  logic           drained;

  logic [W2*2-1:0] din2;
  logic [1:0]      vin2;
  logic [W2*2-1:0] out2;
  logic [1:0]      out_valid2;
  logic [1:0]      lane_busy2;
  logic            drained2;

  always #5 clock = ~clock;

  mesh_pipe_array_valid dut (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .in(din), .in_valid(vin), .out(out), .out_valid(out_valid),
    .lane_busy(lane_busy), .drained(drained)
  );

  mesh_pipe_array_valid #(
    .LSB_PIPE_DEPTH(0), .MID_PIPE_DEPTH(2), .MSB_PIPE_DEPTH(1),
    .WIDTH(W2), .PIPE_ARRAY_SIZE(2)
  ) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .in(din2), .in_valid(vin2), .out(out2), .out_valid(out_valid2),
    .lane_busy(lane_busy2), .drained(drained2)
  );

  // Scoreboard: one queue per lane, front entry = what the lane outputs now.
  typedef logic [W:0] ent_t;
  ent_t lq [N][$];

  logic [W*N-1:0] exp_out;
  logic [N-1:0]   exp_ov;
  logic [N-1:0]   exp_busy;
  logic           exp_drained;
  int n_vec = 0;
  int n_err = 0;

  task automatic model_eval();
    ent_t e;
    for (int i = 0; i < N; i++) begin
      e = lq[i][0];
      exp_out[i*W +: W] = e[W-1:0];
      exp_ov[i]         = e[W];
      exp_busy[i]       = 1'b0;
      for (int k = 0; k < DEP[i]; k++) begin
        e = lq[i][k];
        if (e[W]) exp_busy[i] = 1'b1;
      end
    end
    exp_drained = ~|exp_busy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      for (int k = 0; k < DEP[i]; k++) lq[i].push_back('0);
    end
    model_eval();
  endtask

  task automatic step(input logic en, input logic fl, input logic [W*N-1:0] d, input logic [N-1:0] v);
    ent_t e;
    enable = en; flush = fl; din = d; vin = v;
    @(posedge clock);
    if (fl) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < DEP[i]; k++) begin
          e = lq[i][k]; e[W] = 1'b0; lq[i][k] = e;
        end
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        lq[i].push_back({v[i], d[i*W +: W]});
        void'(lq[i].pop_front());
      end
    end
    model_eval();
    #1;
  endtask

  function automatic logic [W*N-1:0] rand_data();
    logic [W*N-1:0] r;
    for (int i = 0; i < W*N; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    logic [W*N-1:0] d;
    reset = 1'b1; enable = 1'b0; flush = 1'b0; din = '0; vin = '0; din2 = '0; vin2 = '0;
    #2;
    model_reset();
    n_vec++;
    if (out !== '0 || out_valid !== '0 || lane_busy !== '0 || drained !== 1'b1) begin
      n_err++;
      $display("FAIL reset_init out=%h ov=%b busy=%b drained=%b want 0/0/0/1", out, out_valid, lane_busy, drained);
    end
    @(negedge clock); reset = 1'b0;
    d = rand_data();
    step(1'b1, 1'b0, d, 4'b0110);
    d = rand_data();
    step(1'b1, 1'b0, d, 4'b0010);
    n_vec++;
    if (out !== exp_out || out_valid !== exp_ov || lane_busy !== exp_busy || drained !== exp_drained) begin
      n_err++;
      $display("FAIL reset_inflight ov=%b busy=%b drained=%b want ov=%b busy=%b drained=%b",
               out_valid, lane_busy, drained, exp_ov, exp_busy, exp_drained);
    end
    #2; reset = 1'b1; #1;
    n_vec++;
    if (out !== '0 || out_valid !== '0 || lane_busy !== '0 || drained !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async out=%h ov=%b busy=%b drained=%b want 0/0/0/1", out, out_valid, lane_busy, drained);
    end
    model_reset();
    #2; reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [W*N-1:0] d;
    d = '0; d[1*W +: W] = 36'hABC;
    step(1'b1, 1'b0, d, 4'b0010);
    n_vec++;
    if (out_valid[1] !== 1'b0 || lane_busy[1] !== 1'b1 || out_valid !== exp_ov || lane_busy !== exp_busy) begin
      n_err++;
      $display("FAIL latency_e1 ov=%b busy=%b want ov1=0 busy1=1", out_valid, lane_busy);
    end
    step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (out[1*W +: W] !== 36'hABC || out_valid[1] !== 1'b1 || lane_busy[1] !== 1'b1 || out !== exp_out) begin
      n_err++;
      $display("FAIL latency_e2 out1=%h ov=%b busy=%b want abc/1/1", out[1*W +: W], out_valid, lane_busy);
    end
    step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (out_valid[1] !== 1'b0 || lane_busy[1] !== 1'b0 || drained !== 1'b1) begin
      n_err++;
      $display("FAIL latency_e3 ov=%b busy=%b drained=%b want ov1=0 busy1=0 drained=1", out_valid, lane_busy, drained);
    end
  endtask

  task automatic test_stall();
    logic [W*N-1:0] d;
    logic [W*N-1:0] held;
    logic [N-1:0]   held_v;
    d = rand_data(); d[1*W +: W] = 36'h5A5;
    step(1'b1, 1'b0, d, 4'b0010);
    held = out; held_v = out_valid;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, rand_data(), 4'b1111);
      n_vec++;
      if (out !== held || out_valid !== held_v || out !== exp_out || lane_busy !== exp_busy) begin
        n_err++;
        $display("FAIL stall_hold c=%0d ov=%b busy=%b want ov=%b busy=%b", c, out_valid, lane_busy, held_v, exp_busy);
      end
    end
    step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (out[1*W +: W] !== 36'h5A5 || out_valid[1] !== 1'b1 || out !== exp_out || out_valid !== exp_ov) begin
      n_err++;
      $display("FAIL stall_exit out1=%h ov=%b want 5a5 ov1=1", out[1*W +: W], out_valid);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, rand_data(), 4'b1111);
    step(1'b1, 1'b1, rand_data(), 4'b1111);
    n_vec++;
    if (out_valid !== '0 || lane_busy !== '0 || drained !== 1'b1 || out !== exp_out) begin
      n_err++;
      $display("FAIL flush ov=%b busy=%b drained=%b want 0/0/1", out_valid, lane_busy, drained);
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, '0, '0);
      n_vec++;
      if (out_valid !== '0 || drained !== 1'b1 || out !== exp_out) begin
        n_err++;
        $display("FAIL flush_after c=%0d ov=%b drained=%b want ov=0 drained=1", c, out_valid, drained);
      end
    end
  endtask

  task automatic test_stream();
    logic [3:0] pat;
    logic       en;
    pat = 4'b1101;  // cycle order 1,0,1,1 read from bit 0 upward
    for (int c = 0; c < 24; c++) begin
      en = (c < 12) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      step(en, 1'b0, rand_data(), {N{pat[c % 4]}});
      n_vec++;
      if (out !== exp_out || out_valid !== exp_ov || lane_busy !== exp_busy || drained !== exp_drained) begin
        n_err++;
        $display("FAIL stream c=%0d ov=%b busy=%b drained=%b want ov=%b busy=%b drained=%b",
                 c, out_valid, lane_busy, drained, exp_ov, exp_busy, exp_drained);
      end
    end
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (drained !== 1'b1 || lane_busy !== '0) begin
      n_err++;
      $display("FAIL stream_drain busy=%b drained=%b want 0/1", lane_busy, drained);
    end
  endtask

  task automatic test_edge_cfg();
    for (int c = 0; c < 6; c++) begin
      din2 = {8'h00, 8'($urandom)}; vin2 = {1'b0, 1'($urandom)};
      #1;
      n_vec++;
      if (out2[W2-1:0] !== din2[W2-1:0] || out_valid2[0] !== vin2[0] || lane_busy2[0] !== 1'b0 || drained2 !== 1'b1) begin
        n_err++;
        $display("FAIL edge_lane0 c=%0d out=%h ov=%b busy=%b drained=%b want out=%h ov0=%b busy0=0 drained=1",
                 c, out2[W2-1:0], out_valid2, lane_busy2, drained2, din2[W2-1:0], vin2[0]);
      end
      step(1'b1, 1'b0, '0, '0);
    end
    din2 = {8'h3C, 8'h00}; vin2 = 2'b10;
    step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (out2[2*W2-1:W2] !== 8'h3C || out_valid2 !== 2'b10 || lane_busy2 !== 2'b10 || drained2 !== 1'b0) begin
      n_err++;
      $display("FAIL edge_lane1 out1=%h ov=%b busy=%b drained=%b want 3c/10/10/0", out2[2*W2-1:W2], out_valid2, lane_busy2, drained2);
    end
    din2 = '0; vin2 = '0;
    step(1'b1, 1'b0, '0, '0);
    n_vec++;
    if (lane_busy2 !== 2'b00 || drained2 !== 1'b1) begin
      n_err++;
      $display("FAIL edge_drain busy=%b drained=%b want 00/1", lane_busy2, drained2);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_stream();
    test_edge_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
